pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
Generic elastic pipeline-stage register, the parametrised successor to the fixed decode-to-execute register. It carries one data bundle and one control bundle between two pipeline stages. A valid/ready handshake plus a 2-entry skid buffer give full throughput with a registered upstream ready. Flush inserts bubbles that carry all-zero control, so a flushed slot never writes the register file or memory. It is instantiated between decode/execute, execute/memory and memory/writeback.

Parameters:
DATA_WIDTH, 32, width of the data bundle (operands, immediates, PC+4, register addresses, packed by the instantiating stage)
CTRL_WIDTH, 10, width of the control bundle (RegWrite, MemtoReg, MemWrite, ALUControl, ALUSrc, RegDst packed); all-zero is the NOP encoding
CNT_WIDTH, 16, width of each statistics counter (used only with STAT_CNT_EN)

Ports:
i_CLK  in  1  clock, rising edge
i_RST  in  1  reset; synchronous, active-high
i_CLR  in  1  synchronous flush; drops every held beat
i_ValidD  in  1  upstream beat valid
o_ReadyD  out  1  upstream may send; registered
i_DataD  in  DATA_WIDTH  upstream data bundle
i_CtrlD  in  CTRL_WIDTH  upstream control bundle
o_ValidE  out  1  downstream beat valid
i_ReadyE  in  1  downstream accepts
o_DataE  out  DATA_WIDTH  downstream data bundle
o_CtrlE  out  CTRL_WIDTH  downstream control bundle; zero whenever o_ValidE=0
o_Occ  out  2  occupancy: 0, 1 or 2
i_CntClr  in  1  synchronous clear of the statistics counters
o_StallCnt  out  CNT_WIDTH  count of downstream stall cycles
o_FlushCnt  out  CNT_WIDTH  count of flushes that dropped at least one beat

Behaviour:
- Handshake terms:
  - Accept = i_ValidD & o_ReadyD.
  - Emit = o_ValidE & i_ReadyE.
  - Upstream must hold i_DataD and i_CtrlD stable while i_ValidD=1 and o_ReadyD=0.
- Storage: a main register drives the outputs; a skid register holds the overflow beat.
- States, with o_Occ = 0, 1, 2:
  - EMPTY:
    - Accept -> main<=in, go ONE.
  - ONE:
    - Accept & Emit -> main<=in, stay ONE.
    - Accept only -> skid<=in, go FULL.
    - Emit only -> go EMPTY.
    - Neither -> hold.
  - FULL:
    - Emit -> main<=skid, go ONE.
    - No Accept is possible in FULL.
- o_ReadyD is registered and equals (next state != FULL).
- Latency: 1 cycle from Accept to o_ValidE when EMPTY. Sustained throughput is 1 beat/cycle while i_ReadyE=1.
- Stall (i_ReadyE=0): o_DataE and o_CtrlE hold. In FULL, the skid beat is preserved with no loss and no duplication.
- Order is strictly FIFO; the skid beat is always emitted after the main beat.
- Bubble: whenever a state update leaves o_ValidE=0, o_CtrlE is zero. o_DataE keeps its last value; it is don't-care.
- Flush (i_CLR=1):
  - Next state is EMPTY, o_ValidE=0, o_CtrlE=0, o_ReadyD=1.
  - A beat offered in the same cycle is discarded.
  - An Emit completing in the same cycle counts as delivered downstream.
- Priority: i_RST > i_CLR > handshake.
- Reset values: o_ValidE=0, o_ReadyD=1, o_DataE=0, o_CtrlE=0, o_Occ=0, skid=0, both counters=0.
- Reset mid-stall or mid-FULL discards all beats; there is no residual Emit after reset.

Optional Feature:
- STAT_CNT_EN defined:
  - o_StallCnt increments each cycle with o_ValidE=1 & i_ReadyE=0.
  - o_FlushCnt increments each cycle with i_CLR=1 & o_Occ!=0.
  - Both counters saturate at all-ones (no wrap).
  - i_CntClr zeroes both counters; clear beats increment in the same cycle.
  - Reset zeroes both counters.
- STAT_CNT_EN undefined: the ports remain; o_StallCnt and o_FlushCnt are tied to 0 and no counter flops exist.

Test Plan:
- Reset then streaming: i_ReadyE=1, 8 back-to-back beats (data 0x10..0x17, ctrl 0x001..0x008) -> o_ValidE rises 1 cycle after the first Accept, all 8 beats emerge in order on consecutive cycles, o_ReadyD stays 1, o_Occ=1.
- Skid fill: stream data 0xA0, 0xA1, 0xA2 with i_ReadyE=0 -> 0xA0 held at the output, 0xA1 in skid, o_Occ=2, o_ReadyD=0 one cycle after the second Accept, 0xA2 held upstream; on i_ReadyE=1 the output shows 0xA0, 0xA1, 0xA2 in order with no loss or duplicate.
- Flush in FULL with a simultaneous upstream beat 0xB5 -> next cycle o_ValidE=0, o_CtrlE=0, o_Occ=0, o_ReadyD=1; 0xB5 never appears; o_FlushCnt=1 (STAT_CNT_EN).
- Reset during FULL with i_CLR=1 asserted in the same cycle -> all outputs at reset values; o_FlushCnt=0; the next beat 0xC3 emerges with 1-cycle latency.
- STAT_CNT_EN with CNT_WIDTH=4: hold o_ValidE=1, i_ReadyE=0 for 20 cycles -> o_StallCnt=15 (saturated); i_CntClr pulse -> 0; without the macro -> both counters read 0 throughout.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, 2-entry skid buffer, registered upstream ready.
// Optional build macro STAT_CNT_EN adds saturating stall/flush statistics counters.
module pipe_stage_skid_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_CLR,
  input  logic                  i_ValidD,
  output logic                  o_ReadyD,
  input  logic [DATA_WIDTH-1:0] i_DataD,
  input  logic [CTRL_WIDTH-1:0] i_CtrlD,
  output logic                  o_ValidE,
  input  logic                  i_ReadyE,
  output logic [DATA_WIDTH-1:0] o_DataE,
  output logic [CTRL_WIDTH-1:0] o_CtrlE,
  output logic [1:0]            o_Occ,
  input  logic                  i_CntClr,
  output logic [CNT_WIDTH-1:0]  o_StallCnt,
  output logic [CNT_WIDTH-1:0]  o_FlushCnt
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic                  ready_reg;
  logic [DATA_WIDTH-1:0] main_data_reg, main_data_next;
  logic [CTRL_WIDTH-1:0] main_ctrl_reg, main_ctrl_next;
  logic [DATA_WIDTH-1:0] skid_data_reg, skid_data_next;
  logic [CTRL_WIDTH-1:0] skid_ctrl_reg, skid_ctrl_next;
  logic                  accept;
  logic                  emit;

  assign accept = i_ValidD & ready_reg;
  assign emit   = (state_reg != EMPTY) & i_ReadyE;

  always_comb begin
    state_next     = state_reg;
    main_data_next = main_data_reg;
    main_ctrl_next = main_ctrl_reg;
    skid_data_next = skid_data_reg;
    skid_ctrl_next = skid_ctrl_reg;
    if (i_CLR) begin
      // Bubble carries NOP control; data is left as don't-care.
      state_next     = EMPTY;
      main_ctrl_next = '0;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (accept) begin
            main_data_next = i_DataD;
            main_ctrl_next = i_CtrlD;
            state_next     = ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_data_next = i_DataD;
            main_ctrl_next = i_CtrlD;
          end else if (accept) begin
            skid_data_next = i_DataD;
            skid_ctrl_next = i_CtrlD;
            state_next     = FULL;
          end else if (emit) begin
            main_ctrl_next = '0;
            state_next     = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            main_data_next = skid_data_reg;
            main_ctrl_next = skid_ctrl_reg;
            state_next     = ONE;
          end
        end
        default: begin
          state_next     = EMPTY;
          main_ctrl_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_reg     <= EMPTY;
      ready_reg     <= 1'b1;
      main_data_reg <= '0;
      main_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ready_reg     <= (state_next != FULL);
      main_data_reg <= main_data_next;
      main_ctrl_reg <= main_ctrl_next;
      skid_data_reg <= skid_data_next;
      skid_ctrl_reg <= skid_ctrl_next;
    end
  end

  assign o_ReadyD = ready_reg;
  assign o_ValidE = (state_reg != EMPTY);
  assign o_DataE  = main_data_reg;
  assign o_CtrlE  = main_ctrl_reg;
  assign o_Occ    = state_reg;

`ifdef STAT_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_reg;
  logic [CNT_WIDTH-1:0] flush_cnt_reg;
  logic                 stall_inc;
  logic                 flush_inc;

  assign stall_inc = o_ValidE & ~i_ReadyE;
  assign flush_inc = i_CLR & (state_reg != EMPTY);

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge i_CLK) begin
    if (i_RST || i_CntClr) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_inc && (stall_cnt_reg != {CNT_WIDTH{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_inc && (flush_cnt_reg != {CNT_WIDTH{1'b1}}))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign o_StallCnt = stall_cnt_reg;
  assign o_FlushCnt = flush_cnt_reg;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = i_CntClr;
  assign o_StallCnt     = '0;
  assign o_FlushCnt     = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: a queue-based model predicts held beats, ready and counters;
// a negedge monitor compares the DUT against it. Counter expectations follow STAT_CNT_EN.
module tb_pipe_stage_skid_reg;
  localparam int DW   = 32;
  localparam int CW   = 10;
  localparam int NW   = 4;
  localparam int CMAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          valid_d = 1'b0;
  logic          ready_e = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [DW-1:0] data_d = '0;
  logic [CW-1:0] ctrl_d = '0;
  logic          ready_d;
  logic          valid_e;
  logic [DW-1:0] data_e;
  logic [CW-1:0] ctrl_e;
  logic [1:0]    occ;
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] flush_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .i_CLK(clk), .i_RST(rst), .i_CLR(clr),
    .i_ValidD(valid_d), .o_ReadyD(ready_d), .i_DataD(data_d), .i_CtrlD(ctrl_d),
    .o_ValidE(valid_e), .i_ReadyE(ready_e), .o_DataE(data_e), .o_CtrlE(ctrl_e),
    .o_Occ(occ), .i_CntClr(cnt_clr), .o_StallCnt(stall_cnt), .o_FlushCnt(flush_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  beat_t exp_q[$];
  bit    m_ready = 1'b1;
  bit    m_acc   = 1'b0;
  int    m_stall = 0;
  int    m_flush = 0;
  bit    armed   = 1'b0;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of at most two beats.
  always @(posedge clk) begin
    int n;
    n = exp_q.size();
    m_acc = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_ready = 1'b1;
      m_stall = 0;
      m_flush = 0;
      armed   = 1'b1;
    end else begin
      if (cnt_clr) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (n > 0 && !ready_e && m_stall < CMAX) m_stall++;
        if (clr && n > 0 && m_flush < CMAX) m_flush++;
      end
      if (clr) begin
        exp_q.delete();
        m_ready = 1'b1;
      end else begin
        if (n > 0 && ready_e) void'(exp_q.pop_front());
        if (valid_d && m_ready) begin
          exp_q.push_back('{d: data_d, c: ctrl_d});
          m_acc = 1'b1;
        end
        m_ready = (exp_q.size() < 2);
      end
    end
  end

  // Monitor: compares the presented output against the head of the expected queue.
  always @(negedge clk) begin
    if (armed) begin
      check("valid", 64'(valid_e), 64'(exp_q.size() > 0));
      check("occ", 64'(occ), 64'(exp_q.size()));
      check("ready", 64'(ready_d), 64'(m_ready));
      if (exp_q.size() > 0) begin
        check("data", 64'(data_e), 64'(exp_q[0].d));
        check("ctrl", 64'(ctrl_e), 64'(exp_q[0].c));
        if (valid_e && ready_e)
          $display("beat emitted data=%08h ctrl=%03h t=%0t", data_e, ctrl_e, $time);
      end else begin
        check("bubble_ctrl", 64'(ctrl_e), 64'd0);
      end
`ifdef STAT_CNT_EN
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`else
      check("stall_cnt_off", 64'(stall_cnt), 64'd0);
      check("flush_cnt_off", 64'(flush_cnt), 64'd0);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until the model says it was taken (bounded).
  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c);
    int n;
    n = 0;
    valid_d = 1'b1;
    data_d  = d;
    ctrl_d  = c;
    do begin
      cyc();
      n++;
    end while (!m_acc && n < 60);
    check("send_accept", 64'(m_acc), 64'd1);
    valid_d = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_data", 64'(data_e), 64'd0);

    // Back-to-back streaming
    ready_e = 1'b1;
    for (int i = 0; i < 8; i++) send(DW'(32'h10 + i), CW'(i + 1));
    repeat (3) cyc();

    // Skid fill: third beat waits upstream until the stall lifts
    ready_e = 1'b0;
    fork
      begin
        send(32'hA0, 10'h011);
        send(32'hA1, 10'h012);
        send(32'hA2, 10'h013);
      end
      begin
        repeat (6) cyc();
        check("skid_full_occ", 64'(occ), 64'd2);
        ready_e = 1'b1;
      end
    join
    repeat (4) cyc();

    // Flush in FULL with a beat offered in the same cycle
    ready_e = 1'b0;
    send(32'h5A, 10'h021);
    send(32'h5B, 10'h022);
    valid_d = 1'b1;
    data_d  = 32'hB5;
    ctrl_d  = 10'h0B5;
    clr     = 1'b1;
    cyc();
    clr     = 1'b0;
    valid_d = 1'b0;
    check("flush_valid", 64'(valid_e), 64'd0);
    check("flush_ctrl", 64'(ctrl_e), 64'd0);
`ifdef STAT_CNT_EN
    check("flush_cnt_one", 64'(flush_cnt), 64'd1);
`endif
    ready_e = 1'b1;
    repeat (3) cyc();

    // Reset together with flush while FULL
    ready_e = 1'b0;
    send(32'h61, 10'h031);
    send(32'h62, 10'h032);
    rst = 1'b1;
    clr = 1'b1;
    cyc();
    rst = 1'b0;
    clr = 1'b0;
    check("rst_full_data", 64'(data_e), 64'd0);
    check("rst_full_flushcnt", 64'(flush_cnt), 64'd0);
    ready_e = 1'b1;
    send(32'hC3, 10'h0C3);
    check("c3_latency_valid", 64'(valid_e), 64'd1);
    check("c3_latency_data", 64'(data_e), 64'hC3);
    repeat (3) cyc();

    // Stall counter saturation and clear
    ready_e = 1'b0;
    send(32'hD0, 10'h0D0);
    repeat (20) cyc();
`ifdef STAT_CNT_EN
    check("stall_sat", 64'(stall_cnt), 64'(CMAX));
`endif
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    check("stall_clr", 64'(stall_cnt), 64'd0);
    ready_e = 1'b1;
    repeat (3) cyc();

    // Randomized traffic with occasional flush, counter clear and reset
    for (int i = 0; i < 600; i++) begin
      ready_e = ($urandom_range(0, 3) != 0);
      clr     = ($urandom_range(0, 31) == 0);
      cnt_clr = ($urandom_range(0, 63) == 0);
      rst     = ($urandom_range(0, 127) == 0);
      if (!valid_d || m_acc) begin
        valid_d = ($urandom_range(0, 2) != 0);
        data_d  = $urandom();
        ctrl_d  = CW'($urandom());
      end
      cyc();
    end
    rst     = 1'b0;
    clr     = 1'b0;
    cnt_clr = 1'b0;
    valid_d = 1'b0;
    ready_e = 1'b1;
    repeat (5) cyc();
    check("drained_occ", 64'(occ), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
